// File: rtl/ysyx_25040111_axi4_burst_master.sv
// AXI4 burst initiator: turns one command plus a write/read data stream into a single INCR burst.
// One transaction in flight; bursts that would cross a 4KB page are refused without bus activity.
module ysyx_25040111_axi4_burst_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [2:0]            cmd_size,
   input  logic                  wd_valid,
   output logic                  wd_ready,
   input  logic [DATA_W-1:0]     wd_data,
   input  logic [DATA_W/8-1:0]   wd_strb,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  done_valid,
   output logic [1:0]            done_resp,
   output logic [ADDR_W-1:0]     awaddr,
   output logic [7:0]            awlen,
   output logic [2:0]            awsize,
   output logic [1:0]            awburst,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   output logic [ADDR_W-1:0]     araddr,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_W-1:0]     rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready
);

   typedef enum logic [2:0] {
      S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
   } state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   addr_q;
   logic [7:0]          len_q;
   logic [7:0]          beat_q;
   logic [2:0]          size_q;
   logic [1:0]          resp_q;
   logic [16:0]         span_end;
   logic                crosses;
   logic                cmd_fire;
   logic                last_beat;
   logic                w_fire;
   logic                r_fire;
   logic                r_bad;

   // End offset of the burst inside its 4KB page; 17 bits hold 4095 + 256*128.
   assign span_end  = {5'd0, cmd_addr[11:0]} + ({8'd0, {1'b0, cmd_len} + 9'd1} << cmd_size);
   assign crosses   = span_end > 17'd4096;
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign last_beat = beat_q == len_q;
   assign w_fire    = (state == S_W) && wd_valid && wready;
   assign r_fire    = (state == S_R) && rvalid && rd_ready;
   assign r_bad     = rlast != last_beat;

   assign awaddr    = addr_q;
   assign awlen     = len_q;
   assign awsize    = size_q;
   assign awburst   = 2'b01;
   assign araddr    = addr_q;
   assign arlen     = len_q;
   assign arsize    = size_q;
   assign arburst   = 2'b01;
   assign done_resp = resp_q;

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (cmd_fire) state_nx = crosses ? S_DONE : (cmd_write ? S_AW : S_AR);
         S_AW:   if (awready) state_nx = S_W;
         S_W:    if (w_fire && last_beat) state_nx = S_B;
         S_B:    if (bvalid) state_nx = S_DONE;
         S_AR:   if (arready) state_nx = S_R;
         S_R:    if (r_fire && (r_bad || last_beat)) state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Command latch, beat counter and the running worst-case response.
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q <= '0;
         len_q  <= '0;
         size_q <= '0;
         beat_q <= '0;
         resp_q <= '0;
      end else if (cmd_fire) begin
         addr_q <= cmd_addr;
         len_q  <= cmd_len;
         size_q <= cmd_size;
         beat_q <= '0;
         resp_q <= crosses ? 2'b10 : 2'b00;
      end else if (w_fire) begin
         if (!last_beat) beat_q <= beat_q + 8'd1;
      end else if ((state == S_B) && bvalid) begin
         resp_q <= bresp;
      end else if (r_fire) begin
         if (r_bad)              resp_q <= 2'b11;
         else if (rresp > resp_q) resp_q <= rresp;
         if (!last_beat) beat_q <= beat_q + 8'd1;
      end
   end

   // Valids depend only on state and the upstream stream, never on their own ready.
   always_comb begin
      cmd_ready  = 1'b0;
      wd_ready   = 1'b0;
      rd_valid   = 1'b0;
      rd_data    = '0;
      done_valid = 1'b0;
      awvalid    = 1'b0;
      wdata      = '0;
      wstrb      = '0;
      wlast      = 1'b0;
      wvalid     = 1'b0;
      bready     = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      case (state)
         S_IDLE: cmd_ready = !reset;
         S_AW:   awvalid = 1'b1;
         S_W: begin
            wvalid   = wd_valid;
            wd_ready = wready;
            wdata    = wd_data;
            wstrb    = wd_strb;
            wlast    = last_beat;
         end
         S_B:    bready = 1'b1;
         S_AR:   arvalid = 1'b1;
         S_R: begin
            rready   = rd_ready;
            rd_valid = rvalid;
            rd_data  = rdata;
         end
         S_DONE: done_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25040111_axi4_burst_master.sv
// Bench for the AXI4 burst master: a small AXI responder with memory, a data source/sink,
// and a scoreboard of expected write beats, read data and completion responses.
module tb_ysyx_25040111_axi4_burst_master;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic        wd_valid, wd_ready;
   logic [31:0] wd_data;
   logic [3:0]  wd_strb;
   logic        rd_valid, rd_ready;
   logic [31:0] rd_data;
   logic        done_valid;
   logic [1:0]  done_resp;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [3:0]  wstrb;

   always #5 clock = ~clock;

   ysyx_25040111_axi4_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .done_valid(done_valid), .done_resp(done_resp),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } wbeat_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] mem [0:1023];
   logic [31:0] wd_q [$];
   wbeat_t      exp_w [$];
   logic [31:0] exp_r [$];
   logic [1:0]  exp_done [$];

   int          aw_wait = 0;
   bit          rd_toggle = 1'b0;
   bit          mirror_en = 1'b0;
   int          r_err_beat = -1;
   int          r_resp_beat = -1;
   logic [1:0]  r_resp_code = 2'b00;
   int          aw_seen = 0;
   int          ar_seen = 0;
   int          w_count = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // AXI responder and stream endpoints: drive at the falling edge, sample handshakes just before the rising edge.
   initial begin : responder
      logic [31:0] w_ptr, r_ptr, aw_addr_s, ar_addr_s, w_data_s;
      logic [3:0]  w_strb_s;
      logic        w_last_s;
      int          r_len, r_beat, aw_stalls;
      bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, b_pend, r_active;
      {aw_hs, w_hs, b_hs, ar_hs, r_hs, b_pend, r_active} = '0;
      w_ptr = '0; r_ptr = '0; r_len = 0; r_beat = 0; aw_stalls = 0;
      aw_addr_s = '0; ar_addr_s = '0; w_data_s = '0; w_strb_s = '0; w_last_s = 1'b0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rd_ready = 0;
      wd_valid = 0; wd_data = 0; wd_strb = 4'hf;
      forever begin
         @(negedge clock);
         if (aw_hs) begin
            w_ptr = aw_addr_s;
            aw_stalls = 0;
         end
         if (w_hs) begin
            for (int b = 0; b < 4; b++)
               if (w_strb_s[b]) mem[w_ptr[11:2]][8*b +: 8] = w_data_s[8*b +: 8];
            w_ptr += 32'd4;
            if (w_last_s) b_pend = 1'b1;
            if (wd_q.size() > 0) void'(wd_q.pop_front());
         end
         if (b_hs) b_pend = 1'b0;
         if (ar_hs) begin
            r_ptr = ar_addr_s; r_len = int'(arlen); r_beat = 0; r_active = 1'b1;
         end
         if (r_hs) begin
            r_beat++;
            r_ptr += 32'd4;
            if (r_beat > r_len) r_active = 1'b0;
         end
         if (awvalid && aw_stalls < aw_wait) begin
            awready = 1'b0;
            aw_stalls++;
         end else begin
            awready = awvalid;
         end
         wready   = 1'b1;
         bvalid   = b_pend;
         bresp    = 2'b00;
         arready  = arvalid;
         rvalid   = r_active;
         rdata    = r_active ? mem[r_ptr[11:2]] : 32'h0;
         rlast    = r_active && ((r_err_beat >= 0) ? (r_beat == r_err_beat) : (r_beat == r_len));
         rresp    = (r_active && r_beat == r_resp_beat) ? r_resp_code : 2'b00;
         rd_ready = rd_toggle ? !rd_ready : 1'b1;
         wd_valid = wd_q.size() > 0;
         wd_data  = wd_valid ? wd_q[0] : 32'h0;
         if (awvalid) aw_seen++;
         if (arvalid) ar_seen++;
         #4;
         if (reset) begin
            {aw_hs, w_hs, b_hs, ar_hs, r_hs, b_pend, r_active} = '0;
            aw_stalls = 0;
            wd_q.delete();
         end else begin
            aw_hs = awvalid && awready;  aw_addr_s = awaddr;
            w_hs  = wvalid && wready;    w_data_s = wdata; w_strb_s = wstrb; w_last_s = wlast;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;  ar_addr_s = araddr;
            r_hs  = rvalid && rready;
         end
      end
   end

   // Scoreboard: pop an expectation whenever the DUT completes a beat or a transaction.
   initial begin : scoreboard
      wbeat_t e;
      forever begin
         @(negedge clock);
         #3;
         if (reset) begin
            exp_w.delete(); exp_r.delete(); exp_done.delete();
         end else begin
            if (wvalid && wready) begin
               w_count++;
               check("w_expected", 64'(exp_w.size() > 0), 1);
               if (exp_w.size() > 0) begin
                  e = exp_w.pop_front();
                  check("wdata", wdata, e.data);
                  check("wlast", wlast, e.last);
               end
            end
            if (rd_valid && rd_ready) begin
               check("r_expected", 64'(exp_r.size() > 0), 1);
               if (exp_r.size() > 0) check("rd_data", rd_data, exp_r.pop_front());
            end
            if (done_valid) begin
               check("done_expected", 64'(exp_done.size() > 0), 1);
               if (exp_done.size() > 0) check("done_resp", done_resp, exp_done.pop_front());
            end
            if (mirror_en && rvalid) check("rready_mirror", rready, rd_ready);
         end
      end
   end

   task automatic applyStimulus(input logic wr, input logic [31:0] a,
                                input logic [7:0] l, input logic [2:0] s);
      @(negedge clock);
      cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_valid = 1'b1;
      #2;
      check("cmd_ready_idle", cmd_ready, 1);
      @(negedge clock);
      cmd_valid = 1'b0;
      #2;
   endtask

   // Waits for done_valid; exp_n is the cycle count from the call, negative to skip the latency check.
   task automatic checkOutput(input string tag, input int exp_n);
      int n = 0;
      while (done_valid !== 1'b1 && n < 300) begin
         @(negedge clock);
         #2;
         n++;
      end
      check({tag, "_done_seen"}, done_valid, 1);
      if (exp_n >= 0) check({tag, "_latency"}, n, exp_n);
      @(negedge clock);
      #2;
      check({tag, "_done_one_cycle"}, done_valid, 0);
      check({tag, "_back_idle"}, cmd_ready, 1);
   endtask

   task automatic pushWrite(input logic [31:0] first, input int beats);
      for (int i = 0; i < beats; i++) begin
         wd_q.push_back(first + i);
         exp_w.push_back({first + 32'(i), i == beats - 1});
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin : stimulus
      int aw0, ar0, base, k;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
      repeat (3) @(negedge clock);
      #2;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_awvalid", awvalid, 0);
      check("rst_arvalid", arvalid, 0);
      check("rst_wvalid", wvalid, 0);
      check("rst_done_valid", done_valid, 0);
      check("rst_done_resp", done_resp, 0);
      check("rst_awaddr", awaddr, 0);
      check("rst_awlen", awlen, 0);
      @(negedge clock);
      reset = 1'b0;
      #2;
      check("rel_cmd_ready", cmd_ready, 1);

      // Four-beat write, zero-wait responder.
      for (int i = 0; i < 4; i++) begin
         wd_q.push_back(32'h11 * (i + 1));
         exp_w.push_back({32'h11 * 32'(i + 1), i == 3});
      end
      exp_done.push_back(2'b00);
      applyStimulus(1'b1, 32'h8000_0000, 8'd3, 3'd2);
      check("t1_awvalid", awvalid, 1);
      check("t1_awaddr", awaddr, 32'h8000_0000);
      check("t1_awlen", awlen, 3);
      check("t1_awsize", awsize, 2);
      check("t1_awburst", awburst, 1);
      check("t1_wvalid_before_aw", wvalid, 0);
      checkOutput("t1", 6);

      // Read back with a toggling sink.
      for (int i = 0; i < 4; i++) exp_r.push_back(32'h11 * (i + 1));
      exp_done.push_back(2'b00);
      rd_toggle = 1'b1; mirror_en = 1'b1;
      applyStimulus(1'b0, 32'h8000_0000, 8'd3, 3'd2);
      check("t2_arvalid", arvalid, 1);
      check("t2_araddr", araddr, 32'h8000_0000);
      check("t2_arlen", arlen, 3);
      check("t2_arsize", arsize, 2);
      check("t2_arburst", arburst, 1);
      checkOutput("t2", -1);
      rd_toggle = 1'b0; mirror_en = 1'b0;

      // 16 bytes from 0xFF8 crosses the page; refused with no bus activity.
      aw0 = aw_seen; ar0 = ar_seen;
      exp_done.push_back(2'b10);
      applyStimulus(1'b1, 32'h8000_0FF8, 8'd3, 3'd2);
      checkOutput("t3", 0);
      check("t3_no_aw", aw_seen, aw0);
      check("t3_no_ar", ar_seen, ar0);

      // 16 bytes from 0xFF0 ends exactly at the page edge and is allowed.
      pushWrite(32'hA0, 4);
      exp_done.push_back(2'b00);
      applyStimulus(1'b1, 32'h8000_0FF0, 8'd3, 3'd2);
      checkOutput("t3b", 6);

      // Early rlast on beat 1 of a four-beat read.
      r_err_beat = 1;
      exp_r.push_back(32'h11); exp_r.push_back(32'h22);
      exp_done.push_back(2'b11);
      applyStimulus(1'b0, 32'h8000_0000, 8'd3, 3'd2);
      checkOutput("t4", 3);
      check("t4_stray_rready", rready, 0);
      check("t4_stray_rd_valid", rd_valid, 0);
      r_err_beat = -1;
      @(negedge clock); reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #2;

      // SLVERR on the first read beat must survive an OKAY on the second.
      r_resp_beat = 0; r_resp_code = 2'b10;
      exp_r.push_back(32'h11); exp_r.push_back(32'h22);
      exp_done.push_back(2'b10);
      applyStimulus(1'b0, 32'h8000_0000, 8'd1, 3'd2);
      checkOutput("tresp", 3);
      r_resp_beat = -1; r_resp_code = 2'b00;

      // AW held off for five cycles.
      aw_wait = 5;
      pushWrite(32'hAB, 1);
      exp_done.push_back(2'b00);
      applyStimulus(1'b1, 32'h8000_0100, 8'd0, 3'd2);
      for (int i = 0; i < 5; i++) begin
         check("t5_awvalid_held", awvalid, 1);
         check("t5_awaddr_stable", awaddr, 32'h8000_0100);
         check("t5_awlen_stable", awlen, 0);
         check("t5_wvalid_low", wvalid, 0);
         @(negedge clock);
         #2;
      end
      checkOutput("t5", 3);
      aw_wait = 0;

      // Minimum latency single-beat write: AW, W, B, DONE.
      pushWrite(32'hCD, 1);
      exp_done.push_back(2'b00);
      applyStimulus(1'b1, 32'h8000_0104, 8'd0, 3'd2);
      checkOutput("t5b", 3);

      // Reset in the middle of beat 2 of an eight-beat write.
      base = w_count;
      pushWrite(32'h60, 8);
      exp_done.push_back(2'b00);
      applyStimulus(1'b1, 32'h8000_0200, 8'd7, 3'd2);
      k = 0;
      while (w_count < base + 2 && k < 50) begin
         @(negedge clock);
         #2;
         k++;
      end
      check("t6_at_beat2", w_count, base + 2);
      check("t6_wvalid_beat2", wvalid, 1);
      reset = 1'b1;
      @(negedge clock);
      #2;
      check("t6_rst_awvalid", awvalid, 0);
      check("t6_rst_wvalid", wvalid, 0);
      check("t6_rst_arvalid", arvalid, 0);
      check("t6_rst_bready", bready, 0);
      check("t6_rst_rready", rready, 0);
      check("t6_rst_done", done_valid, 0);
      check("t6_rst_cmd_ready", cmd_ready, 0);
      @(negedge clock);
      reset = 1'b0;
      #2;
      check("t6_rel_cmd_ready", cmd_ready, 1);
      pushWrite(32'h71, 2);
      exp_done.push_back(2'b00);
      applyStimulus(1'b1, 32'h8000_0300, 8'd1, 3'd2);
      checkOutput("t6_new", 4);

      check("end_exp_w_empty", exp_w.size(), 0);
      check("end_exp_r_empty", exp_r.size(), 0);
      check("end_exp_done_empty", exp_done.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
